// File: rtl/datmem_ls.sv
// Load/store data memory with a RISC-V sized request/response handshake.
// Requests are latched on accept and serviced after WAIT_CYC busy cycles.
module datmem_ls #(
   parameter int unsigned WORDS    = 64,
   parameter int unsigned WAIT_CYC = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_err
);

   localparam int unsigned IW        = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [3:0]  LAST_WAIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
   localparam logic [29:0] WORDS_LIM = 30'(WORDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_RESP
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic [1:0]  r_err;
   logic [31:0] r_mem [WORDS];

   logic        w_accept;
   logic        w_go;
   logic        w_we;
   logic [2:0]  w_funct3;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic [IW-1:0] w_idx;
   logic [31:0] w_rd_word;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_legal;
   logic        w_misal;
   logic        w_oor;
   logic [1:0]  w_err;
   logic [31:0] w_ld;
   logic [31:0] w_rdata;
   logic [3:0]  w_be;
   logic [31:0] w_st_data;
   logic        w_do_write;

   assign w_accept = req_valid & req_ready;

   // With no wait cycles the access happens on the accept edge itself,
   // so the operands come straight from the request port in IDLE.
   assign w_go = ((r_state == S_IDLE) && w_accept && (WAIT_CYC == 0)) ||
                 ((r_state == S_BUSY) && (r_cnt == LAST_WAIT));

   assign w_we     = (r_state == S_IDLE) ? req_we     : r_we;
   assign w_funct3 = (r_state == S_IDLE) ? req_funct3 : r_funct3;
   assign w_addr   = (r_state == S_IDLE) ? req_addr   : r_addr;
   assign w_wdata  = (r_state == S_IDLE) ? req_wdata  : r_wdata;

   assign w_idx     = w_addr[IW+1:2];
   assign w_rd_word = r_mem[w_idx];
   assign w_byte    = w_rd_word[{w_addr[1:0], 3'b000} +: 8];
   assign w_half    = w_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

   always_comb begin
      w_legal = 1'b0;
      case (w_funct3)
         3'b000, 3'b001, 3'b010: w_legal = 1'b1;
         3'b100, 3'b101:         w_legal = ~w_we;
         default:                w_legal = 1'b0;
      endcase
   end

   assign w_misal = ((w_funct3[1:0] == 2'b01) && w_addr[0]) ||
                    ((w_funct3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
   assign w_oor   = (w_addr[31:2] >= WORDS_LIM);

   always_comb begin
      w_err = 2'b00;
      if (!w_legal)
         w_err = 2'b11;
      else if (w_misal)
         w_err = 2'b01;
      else if (w_oor)
         w_err = 2'b10;
   end

   always_comb begin
      w_ld = '0;
      case (w_funct3)
         3'b000:  w_ld = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_ld = {{16{w_half[15]}}, w_half};
         3'b010:  w_ld = w_rd_word;
         3'b100:  w_ld = {24'd0, w_byte};
         3'b101:  w_ld = {16'd0, w_half};
         default: w_ld = '0;
      endcase
   end

   assign w_rdata = ((w_err == 2'b00) && !w_we) ? w_ld : '0;

   always_comb begin
      w_be      = 4'b1111;
      w_st_data = w_wdata;
      case (w_funct3[1:0])
         2'b00: begin
            w_be      = 4'b0001 << w_addr[1:0];
            w_st_data = {4{w_wdata[7:0]}};
         end
         2'b01: begin
            w_be      = w_addr[1] ? 4'b1100 : 4'b0011;
            w_st_data = {2{w_wdata[15:0]}};
         end
         default: begin
            w_be      = 4'b1111;
            w_st_data = w_wdata;
         end
      endcase
   end

   assign w_do_write = w_we && (w_err == 2'b00);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_we     <= 1'b0;
         r_funct3 <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_err    <= '0;
         for (int unsigned i = 0; i < WORDS; i++)
            r_mem[i] <= '0;
      end else begin
         if (w_go) begin
            r_rdata <= w_rdata;
            r_err   <= w_err;
            if (w_do_write) begin
               for (int unsigned l = 0; l < 4; l++)
                  if (w_be[l])
                     r_mem[w_idx][8*l +: 8] <= w_st_data[8*l +: 8];
            end
         end
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_we     <= req_we;
                  r_funct3 <= req_funct3;
                  r_addr   <= req_addr;
                  r_wdata  <= req_wdata;
                  r_cnt    <= '0;
                  r_state  <= (WAIT_CYC == 0) ? S_RESP : S_BUSY;
               end
            end
            S_BUSY: begin
               if (r_cnt == LAST_WAIT)
                  r_state <= S_RESP;
               else
                  r_cnt <= r_cnt + 4'd1;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_state <= S_IDLE;
                  r_rdata <= '0;
                  r_err   <= '0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready = rst && (r_state == S_IDLE);
   assign rsp_valid = rst && (r_state == S_RESP);
   assign rsp_rdata = rst ? r_rdata : '0;
   assign rsp_err   = rst ? r_err   : 2'b00;

endmodule
